// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serial memory sequencer and its load extender.
package mem_pkg;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;
  localparam int         LEN_UNSIGNED_BIT = 2;

  localparam logic [1:0] IO_ADDR_SEL = 2'b11;
  localparam int         IO_SEL_HI   = 17;
  localparam int         IO_SEL_LO   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  // Byte count of an access; the reserved length 11 behaves as a word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_B:   n = 3'd1;
      LEN_H:   n = 3'd2;
      LEN_W:   n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational byte/half/word sign or zero extension of assembled load data.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] raw_in,
  input  logic [2:0]  len_in,
  output logic [31:0] data_out
);

  logic sign_s;

  // Select the extension by access size; bit 2 of the length marks unsigned.
  always_comb begin
    sign_s = ~len_in[LEN_UNSIGNED_BIT];
    case (len_in[1:0])
      LEN_B:   data_out = {{24{sign_s & raw_in[7]}}, raw_in[7:0]};
      LEN_H:   data_out = {{16{sign_s & raw_in[15]}}, raw_in[15:0]};
      LEN_W:   data_out = raw_in;
      default: data_out = raw_in;
    endcase
  end

endmodule

// File: rtl/mem_byte_ctrl.sv
// Byte-serial sequencer turning one byte/half/word request into 8-bit RAM/IO
// bus cycles, with read-latency tracking, UART back-pressure, pause and flush.
module mem_byte_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              flush,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [2:0]        req_len,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        len_q, len_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        i_q, i_d;
  logic [2:0]        c_q, c_d;
  logic              pend_q, pend_d;
  logic [31:0]       buf_q, buf_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_rd_q, resp_rd_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [ADDR_W-1:0] cur_addr_s;
  logic              is_io_s;
  logic              issue_s;
  logic              last_cap_s;
  logic              req_ready_s;
  logic [31:0]       cap_buf_s;
  logic [31:0]       ext_data_s;
  logic [ADDR_W-1:0] mem_a_s;
  logic [7:0]        mem_dout_s;
  logic              mem_wr_s;

  assign cur_addr_s  = base_q + {{(ADDR_W-3){1'b0}}, i_q};
  assign is_io_s     = (cur_addr_s[IO_SEL_HI:IO_SEL_LO] == IO_ADDR_SEL);
  assign issue_s     = (i_q < n_q);
  assign last_cap_s  = pend_q && (c_q == (n_q - 3'd1));
  assign req_ready_s = rst_n_in && (state_q == IDLE) && !flush && rdy_in;

  // Current read buffer with the byte arriving this cycle merged into lane c.
  always_comb begin
    cap_buf_s = buf_q;
    cap_buf_s[{c_q[1:0], 3'b000} +: 8] = mem_din;
  end

  mem_load_ext u_load_ext (
    .raw_in   (cap_buf_s),
    .len_in   (len_q),
    .data_out (ext_data_s)
  );

  // Next-state, pointer and bus-drive logic for the three-state sequencer.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    n_d          = n_q;
    i_d          = i_q;
    c_d          = c_q;
    pend_d       = pend_q;
    buf_d        = buf_q;
    resp_valid_d = 1'b0;
    resp_rd_d    = resp_rd_q;
    resp_rdata_d = resp_rdata_q;
    mem_a_s      = {ADDR_W{1'b0}};
    mem_dout_s   = 8'h00;
    mem_wr_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_s) begin
          base_d  = req_addr;
          len_d   = req_len;
          wdata_d = req_wdata;
          n_d     = len_to_bytes(req_len[1:0]);
          i_d     = 3'd0;
          c_d     = 3'd0;
          pend_d  = 1'b0;
          buf_d   = 32'h0000_0000;
          state_d = req_wr ? WR : RD;
        end else begin
          state_d = IDLE;
        end
      end

      RD: begin
        mem_a_s = cur_addr_s;
        if (flush) begin
          pend_d  = 1'b0;
          state_d = IDLE;
        end else if (!rdy_in) begin
          // Rewind to the first uncaptured byte; its address must be re-issued.
          i_d    = c_q;
          pend_d = 1'b0;
        end else begin
          pend_d = issue_s;
          if (issue_s) begin
            i_d = i_q + 3'd1;
          end else begin
            i_d = i_q;
          end
          if (pend_q) begin
            buf_d = cap_buf_s;
            c_d   = c_q + 3'd1;
            if (last_cap_s) begin
              state_d      = IDLE;
              resp_valid_d = 1'b1;
              resp_rd_d    = 1'b1;
              resp_rdata_d = ext_data_s;
            end else begin
              state_d = RD;
            end
          end else begin
            c_d = c_q;
          end
        end
      end

      WR: begin
        mem_a_s    = cur_addr_s;
        mem_dout_s = wdata_q[{i_q[1:0], 3'b000} +: 8];
        if (rdy_in && !(is_io_s && io_buffer_full)) begin
          mem_wr_s = 1'b1;
          i_d      = i_q + 3'd1;
          if (i_q == (n_q - 3'd1)) begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_rd_d    = 1'b0;
            resp_rdata_d = 32'h0000_0000;
          end else begin
            state_d = WR;
          end
        end else begin
          i_d = i_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and response registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      base_q       <= {ADDR_W{1'b0}};
      len_q        <= 3'd0;
      wdata_q      <= 32'h0000_0000;
      n_q          <= 3'd0;
      i_q          <= 3'd0;
      c_q          <= 3'd0;
      pend_q       <= 1'b0;
      buf_q        <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      n_q          <= n_d;
      i_q          <= i_d;
      c_q          <= c_d;
      pend_q       <= pend_d;
      buf_q        <= buf_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign mem_a      = mem_a_s;
  assign mem_dout   = mem_dout_s;
  assign mem_wr     = mem_wr_s;
  assign req_ready  = req_ready_s;
  // A read completion landing on a flush cycle belongs to a squashed request.
  assign resp_valid = resp_valid_q && !(flush && resp_rd_q);
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Directed self-checking bench for mem_byte_ctrl with a one-cycle-latency RAM model.
module tb_mem_byte_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        flush;
  logic        req_valid;
  logic        req_wr;
  logic [2:0]  req_len;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  mem_byte_ctrl #(.ADDR_W(32)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_wr         (req_wr),
    .req_len        (req_len),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram [0:262143];

  // Read data appears one cycle after its address.
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[17:0]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  int          resp_at;
  int          nresp;
  int          nwr;
  logic [31:0] rdata;
  int          wr_cyc  [0:7];
  logic [7:0]  wr_byte [0:7];
  logic [31:0] wr_addr [0:7];
  logic        rr      [0:23];
  logic [31:0] ma      [0:23];

  task automatic drive_idle();
    req_valid      = 1'b0;
    req_wr         = 1'b0;
    req_len        = 3'd0;
    req_addr       = 32'd0;
    req_wdata      = 32'd0;
    io_buffer_full = 1'b0;
    flush          = 1'b0;
    rdy_in         = 1'b1;
  endtask

  // Cycle r = 0 is the acceptance cycle; observations are relative to it.
  task automatic run_txn(input logic wr, input logic [2:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, input int full_lo, input int full_hi,
                         input int rdy_lo, input int rdy_hi, input int flush_at);
    resp_at = -1;
    nresp   = 0;
    nwr     = 0;
    rdata   = 32'd0;
    for (int r = 0; r < 24; r++) begin
      @(negedge clk_in);
      req_valid      = (r == 0);
      req_wr         = wr;
      req_len        = len;
      req_addr       = addr;
      req_wdata      = wdata;
      io_buffer_full = (r >= full_lo) && (r <= full_hi);
      rdy_in         = !((r >= rdy_lo) && (r <= rdy_hi));
      flush          = (r == flush_at);
      #1;
      rr[r] = req_ready;
      ma[r] = mem_a;
      if (r == 0) check_val("accept", {31'd0, req_ready}, 32'd1);
      if (resp_valid) begin
        nresp++;
        if (resp_at < 0) begin
          resp_at = r;
          rdata   = resp_rdata;
        end
      end
      if (mem_wr && (nwr < 8)) begin
        wr_cyc[nwr]  = r;
        wr_byte[nwr] = mem_dout;
        wr_addr[nwr] = mem_a;
        nwr++;
      end
    end
    drive_idle();
  endtask

  initial begin
    for (int k = 0; k < 262144; k++) ram[k] = 8'h00;
    ram[18'h00100] = 8'h11; ram[18'h00101] = 8'h22;
    ram[18'h00102] = 8'h33; ram[18'h00103] = 8'h44;
    ram[18'h00200] = 8'h80;
    ram[18'h00202] = 8'h34; ram[18'h00203] = 8'h9A;
    ram[18'h3FFFE] = 8'h5A; ram[18'h3FFFF] = 8'h6B;
    ram[18'h00000] = 8'h7C; ram[18'h00001] = 8'h8D;

    drive_idle();
    rst_n_in = 1'b0;
    @(negedge clk_in); #1;
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check_val("rst_mem_a", mem_a, 32'd0);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Word read
    run_txn(1'b0, 3'b010, 32'h100, 32'd0, 99, 99, 99, 99, 99);
    check_val("wrd_resp_cyc", resp_at, 32'd6);
    check_val("wrd_rdata", rdata, 32'h44332211);
    check_val("wrd_npulse", nresp, 32'd1);
    check_val("wrd_addr0", ma[1], 32'h100);
    check_val("wrd_addr3", ma[4], 32'h103);
    check_val("wrd_nwr", nwr, 32'd0);
    check_val("wrd_idle_a", ma[8], 32'd0);

    // Byte reads, signed and unsigned
    run_txn(1'b0, 3'b000, 32'h200, 32'd0, 99, 99, 99, 99, 99);
    check_val("sb_resp_cyc", resp_at, 32'd3);
    check_val("sb_rdata", rdata, 32'hFFFFFF80);
    run_txn(1'b0, 3'b100, 32'h200, 32'd0, 99, 99, 99, 99, 99);
    check_val("ub_rdata", rdata, 32'h00000080);

    // Half reads, negative and positive
    run_txn(1'b0, 3'b001, 32'h202, 32'd0, 99, 99, 99, 99, 99);
    check_val("sh_resp_cyc", resp_at, 32'd4);
    check_val("sh_rdata", rdata, 32'hFFFF9A34);
    run_txn(1'b0, 3'b101, 32'h202, 32'd0, 99, 99, 99, 99, 99);
    check_val("uh_rdata", rdata, 32'h00009A34);
    run_txn(1'b0, 3'b001, 32'h100, 32'd0, 99, 99, 99, 99, 99);
    check_val("sh_pos_rdata", rdata, 32'h00002211);

    // Reserved length 11 reads a word; address wraps past 2^32
    run_txn(1'b0, 3'b011, 32'hFFFFFFFE, 32'd0, 99, 99, 99, 99, 99);
    check_val("wrap_rdata", rdata, 32'h8D7C6B5A);
    check_val("wrap_addr2", ma[3], 32'h00000000);
    check_val("wrap_resp_cyc", resp_at, 32'd6);

    // IO halfword write held off by a full UART FIFO
    run_txn(1'b1, 3'b001, 32'h30000, 32'h0000BEEF, 1, 3, 99, 99, 99);
    check_val("io_nwr", nwr, 32'd2);
    check_val("io_wr0_cyc", wr_cyc[0], 32'd4);
    check_val("io_wr0_byte", {24'd0, wr_byte[0]}, 32'hEF);
    check_val("io_wr0_addr", wr_addr[0], 32'h30000);
    check_val("io_wr1_cyc", wr_cyc[1], 32'd5);
    check_val("io_wr1_byte", {24'd0, wr_byte[1]}, 32'hBE);
    check_val("io_wr1_addr", wr_addr[1], 32'h30001);
    check_val("io_stall_addr", ma[2], 32'h30000);
    check_val("io_resp_cyc", resp_at, 32'd6);
    check_val("io_resp_data", rdata, 32'd0);

    // rdy_in low for two cycles in the middle of a word read
    run_txn(1'b0, 3'b010, 32'h100, 32'd0, 99, 99, 3, 4, 99);
    check_val("rdy_resp_cyc", resp_at, 32'd9);
    check_val("rdy_rdata", rdata, 32'h44332211);
    check_val("rdy_npulse", nresp, 32'd1);

    // Flush aborts a read, then a new request is taken
    run_txn(1'b0, 3'b010, 32'h100, 32'd0, 99, 99, 99, 99, 2);
    check_val("flrd_npulse", nresp, 32'd0);
    check_val("flrd_ready", {31'd0, rr[3]}, 32'd1);
    check_val("flrd_idle_a", ma[3], 32'd0);
    run_txn(1'b0, 3'b100, 32'h200, 32'd0, 99, 99, 99, 99, 99);
    check_val("flrd_next", rdata, 32'h00000080);

    // Flush on the read completion cycle suppresses the pulse
    run_txn(1'b0, 3'b010, 32'h100, 32'd0, 99, 99, 99, 99, 6);
    check_val("flresp_npulse", nresp, 32'd0);

    // Flush cannot abort a write; non-IO bytes ignore a full FIFO
    run_txn(1'b1, 3'b010, 32'h400, 32'hA1B2C3D4, 1, 4, 99, 99, 2);
    check_val("flwr_nwr", nwr, 32'd4);
    check_val("flwr_b0", {wr_cyc[0][7:0], wr_byte[0], wr_addr[0][15:0]}, 32'h01D40400);
    check_val("flwr_b1", {wr_cyc[1][7:0], wr_byte[1], wr_addr[1][15:0]}, 32'h02C30401);
    check_val("flwr_b2", {wr_cyc[2][7:0], wr_byte[2], wr_addr[2][15:0]}, 32'h03B20402);
    check_val("flwr_b3", {wr_cyc[3][7:0], wr_byte[3], wr_addr[3][15:0]}, 32'h04A10403);
    check_val("flwr_resp_cyc", resp_at, 32'd5);

    // Leave a nonzero response behind, then reset in the middle of a write
    run_txn(1'b0, 3'b010, 32'h100, 32'd0, 99, 99, 99, 99, 99);
    @(negedge clk_in);
    req_valid = 1'b1; req_wr = 1'b1; req_len = 3'b010;
    req_addr = 32'h500; req_wdata = 32'h01020304;
    #1;
    check_val("rstw_accept", {31'd0, req_ready}, 32'd1);
    @(negedge clk_in);
    req_valid = 1'b0;
    @(negedge clk_in); #1;
    check_val("rstw_pre_wr", {31'd0, mem_wr}, 32'd1);
    rst_n_in = 1'b0;
    #1;
    check_val("rstw_mem_wr", {31'd0, mem_wr}, 32'd0);
    check_val("rstw_mem_a", mem_a, 32'd0);
    check_val("rstw_mem_dout", {24'd0, mem_dout}, 32'd0);
    check_val("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rstw_resp_rdata", resp_rdata, 32'd0);
    check_val("rstw_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in); #1;
    check_val("rstw_post_ready", {31'd0, req_ready}, 32'd1);
    check_val("rstw_post_wr", {31'd0, mem_wr}, 32'd0);
    check_val("rstw_post_a", mem_a, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_byte_ctrl.md
# mem_byte_ctrl

Byte-serial sequencer between the CPU's single memory request port and the 8-bit external RAM/IO bus. It accepts one byte, halfword or word access, issues the required byte reads or writes on `mem_a`/`mem_dout`/`mem_wr`, and returns one assembled, sign- or zero-extended result. It sits directly below the inst/data request arbiter and drives the chip-level RAM pins. It handles RAM read latency, UART back-pressure, `rdy_in` pauses and pipeline flush.

## Interface
Parameters:
- `ADDR_W`, 32: address width. Addresses wrap modulo 2^ADDR_W.

Ports:
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: reset. Asynchronous assert, active-low.
- `rdy_in` in 1: global ready. When low, the block pauses.
- `mem_din` in 8: RAM read data. Valid one cycle after its address.
- `mem_dout` out 8: write byte.
- `mem_a` out ADDR_W: byte address.
- `mem_wr` out 1: 1 = write this cycle.
- `io_buffer_full` in 1: UART FIFO full.
- `flush` in 1: pipeline clear (ROB mispredict). Synchronous, active-high.
- `req_valid` in 1: request present. The requester holds it until accepted.
- `req_wr` in 1: 1 = store.
- `req_len` in 3: bit 2 = unsigned. Bits [1:0]: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `req_addr` in ADDR_W: first byte address.
- `req_wdata` in 32: store data, little-endian. `req_wdata[7:0]` goes to `req_addr`.
- `req_ready` out 1: request accepted this cycle. Defined as `state==IDLE && !flush && rdy_in`.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. Write completions return 0.

## Operation
States:
- **IDLE**: accept when `req_valid && req_ready`. Latch addr, len, wdata and wr. Set byte count N = 1/2/4. Go to RD or WR.
- **RD**:
  - Issue pointer `i` drives `mem_a = base+i`.
  - Capture pointer `c` stores `mem_din` into byte lane `c` whenever flag `pend` is set. `pend` is set when an address was issued in the previous active cycle.
  - After the last capture, register the extended result, pulse `resp_valid`, and return to IDLE.
- **WR**:
  - Drive `mem_a = base+i`, `mem_dout = wdata` byte `i`, and `mem_wr = 1`.
  - Advance `i` on each issued byte. After byte N-1, pulse `resp_valid` and return to IDLE.

Boundary behaviour:
- **IO stall**: an address is IO when `addr[17:16] == 2'b11`. For IO bytes in WR, when `io_buffer_full = 1`, drive `mem_wr = 0`, hold `i`, and retry the next cycle.
- **`rdy_in` low**:
  - No state or pointer advance. `mem_wr` is forced to 0.
  - RD sets `i <= c` and `pend <= 0`, so no byte is captured from a stale address.
  - The pending byte is re-issued on resume.
- **`flush`** (regardless of `rdy_in`):
  - RD, or an IDLE acceptance in the same cycle, is aborted. Go to IDLE with no `resp_valid`.
  - WR is never aborted. It completes and its `resp_valid` is still delivered.
  - A read `resp_valid` coinciding with `flush` is suppressed.
- **Extension**:
  - Byte: `{24{signed ? b0[7] : 0}, b0}`.
  - Half: `{16{signed ? b1[7] : 0}, b1, b0}`.
  - Word: `{b3, b2, b1, b0}`.
- **Reset** (`rst_n_in` low):
  - State returns to IDLE at once, whatever operation is in progress. Any partial access is discarded.
  - Outputs `mem_a = 0`, `mem_dout = 0`, `mem_wr = 0`, `resp_valid = 0`, `resp_rdata = 0`, `req_ready = 0`.
- When idle, `mem_a = 0`, `mem_dout = 0`, `mem_wr = 0`.

## Timing
A = the acceptance cycle. Latencies assume no stalls.
- **Write, N bytes**: byte k has `mem_wr = 1` in cycle A+1+k. `resp_valid` is in cycle A+N+1.
- **Read, N bytes**: address k is issued in cycle A+1+k, and its byte is captured at the end of cycle A+2+k. `resp_valid` and `resp_rdata` are registered, in cycle A+N+2.
- **Back-to-back**: the block is back in IDLE during the `resp_valid` cycle, so `req_ready` can be 1 in that same cycle.
- **Stalls**: each stalled cycle (IO full or `rdy_in` low) adds exactly one cycle of latency. In RD, a `rdy_in` stall also re-issues the uncaptured byte, adding one further cycle.

## Structure
- Package `mem_pkg`:
  - `req_len` encodings (`LEN_B`, `LEN_H`, `LEN_W`) and the unsigned bit index.
  - `IO_ADDR_SEL = 2'b11` at `addr[17:16]`.
  - State enum `IDLE`/`RD`/`WR`.
- Sub-module `mem_load_ext`: combinational byte/half/word sign/zero extension. It is shared with the data cache.

## Test plan
- **Word read**: RAM holds 0x11,0x22,0x33,0x44 at 0x100. Read word at 0x100 -> `resp_valid` at A+6, `resp_rdata = 0x44332211`.
- **Signed byte read**: byte 0x80 at 0x200. Signed -> `0xFFFFFF80`; unsigned -> `0x00000080`. `resp_valid` at A+3.
- **IO write stall**: halfword write of 0xBEEF to 0x30000 with `io_buffer_full` high for 3 cycles from A+1 -> 0xEF written at A+4 and 0xBE at A+5; `resp_valid` at A+6; `mem_wr = 0` during the stall.
- **`rdy_in` drop mid-read**: drop `rdy_in` for 2 cycles at A+3 during a word read -> the correct word is still returned; no byte is duplicated or lost.
- **Flush**:
  - During a word read at A+2 -> no `resp_valid`, IDLE next cycle, and the next request is accepted.
  - During a word write at A+2 -> all 4 bytes are written and `resp_valid` occurs at A+5.
- **Reset mid-write**: assert `rst_n_in` low at A+2 of a word write -> `mem_wr = 0` immediately and all outputs at reset values; after release, the block is in IDLE with `req_ready = 1`.
